// File: rtl/pkt_meta_head_arbiter_pkg.sv
// Shared types for the metadata arbiter between packet metadata and head-pointer updates.
package pkt_meta_head_arbiter_pkg;

    localparam int QID_W = 16;

    typedef struct packed {
        logic [QID_W-1:0] pkt_queue_id;
        logic [15:0]      size;
        logic [31:0]      flow_tag;
        logic             needs_dsc;
        logic             descriptor_only;
    } pkt_meta_with_queues_t;

    typedef enum logic {
        PKT_PRIO  = 1'b0,
        HEAD_PRIO = 1'b1
    } arb_state_t;

    // Metadata beat that only asks the queue manager to fetch descriptors.
    function automatic pkt_meta_with_queues_t dsc_only_meta(input logic [QID_W-1:0] qid);
        pkt_meta_with_queues_t m;
        m                 = '0;
        m.pkt_queue_id    = qid;
        m.descriptor_only = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/pkt_meta_head_arbiter_head_upd_coalesce_fifo.sv
// Pending head-update queue; an update whose queue id is already pending is absorbed.
module head_upd_coalesce_fifo #(
    parameter int QID_W = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [QID_W-1:0] upd_queue_id,
    input  logic             upd_valid,
    output logic             upd_ready,
    input  logic             pop,
    output logic             front_valid,
    output logic [QID_W-1:0] front_id,
    output logic             empty,
    output logic             coalesce
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [QID_W-1:0] ids [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [OCC_W-1:0] occ;
    logic             full, accept, hit, push;

    assign full        = (occ == OCC_W'(DEPTH));
    assign empty       = (occ == '0);
    assign upd_ready   = rst_n && !full;
    assign front_valid = vld[rd_ptr];
    assign front_id    = ids[rd_ptr];
    assign accept      = upd_valid && upd_ready;

    // The entry being popped this cycle is still valid, so a match on it coalesces too.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && (ids[i] == upd_queue_id)) hit = 1'b1;
        end
    end

    assign push     = accept && !hit;
    assign coalesce = accept && hit;

    always_ff @(posedge clk) begin
        if (push) ids[wr_ptr] <= upd_queue_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
            vld    <= '0;
        end else begin
            if (push) begin
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pkt_meta_head_arbiter.sv
// Merges packet metadata and head-pointer updates onto the queue manager's single metadata input.
// state     | meaning
// PKT_PRIO  | packets win; counts packet grants while head updates wait
// HEAD_PRIO | burst limit reached; oldest pending head update wins next
module pkt_meta_head_arbiter
    import pkt_meta_head_arbiter_pkg::*;
#(
    parameter int QUEUE_ID_WIDTH  = QID_W,
    parameter int HEAD_FIFO_DEPTH = 8,
    parameter int PKT_BURST_MAX   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  pkt_meta_with_queues_t     in_pkt_data,
    input  logic                      in_pkt_valid,
    output logic                      in_pkt_ready,
    input  logic [QUEUE_ID_WIDTH-1:0] head_upd_queue_id,
    input  logic                      head_upd_valid,
    output logic                      head_upd_ready,
    output pkt_meta_with_queues_t     out_meta_data,
    output logic                      out_meta_valid,
    input  logic                      out_meta_ready,
    output logic [31:0]               merged_cnt,
    output logic [31:0]               dsc_only_cnt,
    output logic [31:0]               coalesced_cnt
);
    localparam int BURST_W = $clog2(PKT_BURST_MAX + 1);

    arb_state_t                state, state_nxt;
    logic [BURST_W-1:0]        burst, burst_nxt;
    logic                      stage_free, front_valid, fifo_empty, coalesce;
    logic [QUEUE_ID_WIDTH-1:0] front_id;
    logic                      do_merge, do_pkt, do_head, pop;
    pkt_meta_with_queues_t     grant_data;

    head_upd_coalesce_fifo #(
        .QID_W (QUEUE_ID_WIDTH),
        .DEPTH (HEAD_FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .upd_queue_id (head_upd_queue_id),
        .upd_valid    (head_upd_valid),
        .upd_ready    (head_upd_ready),
        .pop          (pop),
        .front_valid  (front_valid),
        .front_id     (front_id),
        .empty        (fifo_empty),
        .coalesce     (coalesce)
    );

    assign stage_free   = !out_meta_valid || out_meta_ready;
    assign pop          = do_merge || do_head;
    assign in_pkt_ready = rst_n && (do_merge || do_pkt);

    always_comb begin
        state_nxt = state;
        burst_nxt = burst;
        do_merge  = 1'b0;
        do_pkt    = 1'b0;
        do_head   = 1'b0;
        if (stage_free) begin
            if (in_pkt_valid && front_valid && (in_pkt_data.pkt_queue_id == front_id))
                do_merge = 1'b1;
            else if ((state == HEAD_PRIO) && front_valid)
                do_head = 1'b1;
            else if (in_pkt_valid)
                do_pkt = 1'b1;
            else if (front_valid)
                do_head = 1'b1;
        end
        if (do_merge || do_head) begin
            state_nxt = PKT_PRIO;
            burst_nxt = '0;
        end else if (fifo_empty) begin
            burst_nxt = '0;
        end else if (do_pkt && (state == PKT_PRIO)) begin
            burst_nxt = burst + BURST_W'(1);
            if (burst_nxt == BURST_W'(PKT_BURST_MAX)) state_nxt = HEAD_PRIO;
        end
    end

    always_comb begin
        grant_data                 = in_pkt_data;
        grant_data.needs_dsc       = do_merge;
        grant_data.descriptor_only = 1'b0;
        if (do_head) grant_data = dsc_only_meta(front_id);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= PKT_PRIO;
            burst          <= '0;
            out_meta_valid <= 1'b0;
            out_meta_data  <= '0;
            merged_cnt     <= '0;
            dsc_only_cnt   <= '0;
            coalesced_cnt  <= '0;
        end else begin
            state <= state_nxt;
            burst <= burst_nxt;
            if (stage_free) begin
                out_meta_valid <= do_merge || do_pkt || do_head;
                if (do_merge || do_pkt || do_head) out_meta_data <= grant_data;
            end
            if (do_merge) merged_cnt    <= merged_cnt + 32'd1;
            if (do_head)  dsc_only_cnt  <= dsc_only_cnt + 32'd1;
            if (coalesce) coalesced_cnt <= coalesced_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_pkt_meta_head_arbiter.sv
// Bench for pkt_meta_head_arbiter: directed scenarios then random traffic against a queue-based model.
module tb_pkt_meta_head_arbiter;
    import pkt_meta_head_arbiter_pkg::*;

    localparam int DEPTH     = 8;
    localparam int BURST_MAX = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    pkt_meta_with_queues_t in_pkt_data;
    logic                  in_pkt_valid;
    logic                  in_pkt_ready;
    logic [15:0]           head_upd_queue_id;
    logic                  head_upd_valid;
    logic                  head_upd_ready;
    pkt_meta_with_queues_t out_meta_data;
    logic                  out_meta_valid;
    logic                  out_meta_ready;
    logic [31:0]           merged_cnt, dsc_only_cnt, coalesced_cnt;

    always #5 clk = ~clk;

    pkt_meta_head_arbiter #(
        .QUEUE_ID_WIDTH  (16),
        .HEAD_FIFO_DEPTH (DEPTH),
        .PKT_BURST_MAX   (BURST_MAX)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_pkt_data       (in_pkt_data),
        .in_pkt_valid      (in_pkt_valid),
        .in_pkt_ready      (in_pkt_ready),
        .head_upd_queue_id (head_upd_queue_id),
        .head_upd_valid    (head_upd_valid),
        .head_upd_ready    (head_upd_ready),
        .out_meta_data     (out_meta_data),
        .out_meta_valid    (out_meta_valid),
        .out_meta_ready    (out_meta_ready),
        .merged_cnt        (merged_cnt),
        .dsc_only_cnt      (dsc_only_cnt),
        .coalesced_cnt     (coalesced_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: pending head ids in arrival order, packets granted since one became pending.
    logic [15:0]           pend[$];
    int                    burst;
    bit                    owed;
    bit                    exp_valid;
    pkt_meta_with_queues_t exp_data;
    logic [31:0]           exp_merged, exp_dsc, exp_coal;
    pkt_meta_with_queues_t beats[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        burst      = 0;
        owed       = 1'b0;
        exp_valid  = 1'b0;
        exp_data   = '0;
        exp_merged = '0;
        exp_dsc    = '0;
        exp_coal   = '0;
    endtask

    task automatic reset_checks();
        chk("rst_in_pkt_ready", 128'(in_pkt_ready), 128'(0));
        chk("rst_head_upd_ready", 128'(head_upd_ready), 128'(0));
        chk("rst_out_valid", 128'(out_meta_valid), 128'(0));
        chk("rst_out_data", 128'(out_meta_data), 128'(0));
        chk("rst_merged", 128'(merged_cnt), 128'(0));
        chk("rst_dsc_only", 128'(dsc_only_cnt), 128'(0));
        chk("rst_coalesced", 128'(coalesced_cnt), 128'(0));
    endtask

    task automatic drive(input bit pv, input logic [15:0] pq, input bit hv, input logic [15:0] hq,
                         input bit ordy);
        pkt_meta_with_queues_t d;
        d.pkt_queue_id    = pq;
        d.size            = 16'($urandom);
        d.flow_tag        = $urandom;
        d.needs_dsc       = 1'($urandom);
        d.descriptor_only = 1'($urandom);
        in_pkt_data       = d;
        in_pkt_valid      = pv;
        head_upd_valid    = hv;
        head_upd_queue_id = hq;
        out_meta_ready    = ordy;
    endtask

    // One clock: inputs already driven at the preceding negedge.
    task automatic cycle();
        bit sf, front, merge, pkt_g, head_g, acc, dup;
        pkt_meta_with_queues_t gd;
        #1;
        sf     = !exp_valid || out_meta_ready;
        front  = (pend.size() > 0);
        merge  = 1'b0;
        pkt_g  = 1'b0;
        head_g = 1'b0;
        if (sf) begin
            if (in_pkt_valid && front && in_pkt_data.pkt_queue_id == pend[0]) merge = 1'b1;
            else if (owed && front) head_g = 1'b1;
            else if (in_pkt_valid) pkt_g = 1'b1;
            else if (front) head_g = 1'b1;
        end
        acc = head_upd_valid && (pend.size() < DEPTH);
        chk("in_pkt_ready", 128'(in_pkt_ready), 128'(merge || pkt_g));
        chk("head_upd_ready", 128'(head_upd_ready), 128'(pend.size() < DEPTH));
        if (out_meta_valid && out_meta_ready) beats.push_back(out_meta_data);
        dup = 1'b0;
        foreach (pend[k]) if (pend[k] == head_upd_queue_id) dup = 1'b1;
        gd = '0;
        if (merge || pkt_g) begin
            gd                 = in_pkt_data;
            gd.needs_dsc       = merge;
            gd.descriptor_only = 1'b0;
        end else if (head_g) begin
            gd.descriptor_only = 1'b1;
            gd.pkt_queue_id    = pend[0];
        end
        @(posedge clk);
        if (sf) begin
            exp_valid = merge || pkt_g || head_g;
            if (exp_valid) exp_data = gd;
        end
        if (merge || head_g) void'(pend.pop_front());
        if (acc) begin
            if (dup) exp_coal = exp_coal + 1;
            else pend.push_back(head_upd_queue_id);
        end
        if (merge || head_g) begin
            burst = 0;
            owed  = 1'b0;
        end else if (!front) begin
            burst = 0;
        end else if (pkt_g && !owed) begin
            burst++;
            if (burst == BURST_MAX) owed = 1'b1;
        end
        if (merge)  exp_merged = exp_merged + 1;
        if (head_g) exp_dsc    = exp_dsc + 1;
        @(negedge clk);
        chk("out_valid", 128'(out_meta_valid), 128'(exp_valid));
        if (exp_valid) chk("out_data", 128'(out_meta_data), 128'(exp_data));
        chk("merged_cnt", 128'(merged_cnt), 128'(exp_merged));
        chk("dsc_only_cnt", 128'(dsc_only_cnt), 128'(exp_dsc));
        chk("coalesced_cnt", 128'(coalesced_cnt), 128'(exp_coal));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 16'd0, 1'b0, 16'd0, 1'b1);
            cycle();
        end
    endtask

    task automatic chk_beat(input string tag, input int idx, input logic [15:0] qid, input bit nd,
                            input bit dso);
        pkt_meta_with_queues_t b;
        if (idx < beats.size()) b = beats[idx];
        else b = '1;
        chk({tag, "_qid"}, 128'(b.pkt_queue_id), 128'(qid));
        chk({tag, "_flags"}, 128'({b.needs_dsc, b.descriptor_only}), 128'({nd, dso}));
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 16'd3, 1'b1, 16'd3, 1'b0);
        model_reset();
        #2;
        reset_checks();
        @(negedge clk);
        rst_n = 1'b1;

        // Packets only, back to back.
        beats.delete();
        drive(1'b1, 16'd3, 1'b0, 16'd0, 1'b1); cycle();
        drive(1'b1, 16'd5, 1'b0, 16'd0, 1'b1); cycle();
        drive(1'b1, 16'd7, 1'b0, 16'd0, 1'b1); cycle();
        idle(1);
        chk("s1_beats", 128'(beats.size()), 128'(3));
        chk_beat("s1_b0", 0, 16'd3, 1'b0, 1'b0);
        chk_beat("s1_b1", 1, 16'd5, 1'b0, 1'b0);
        chk_beat("s1_b2", 2, 16'd7, 1'b0, 1'b0);

        // Lone head update becomes a descriptor-only beat.
        beats.delete();
        drive(1'b0, 16'd0, 1'b1, 16'd9, 1'b1); cycle();
        idle(2);
        chk("s2_dsc_only", 128'(dsc_only_cnt), 128'(1));
        chk("s2_beats", 128'(beats.size()), 128'(1));
        chk_beat("s2_b0", 0, 16'd9, 1'b0, 1'b1);

        // Pending head update merges with a same-queue packet.
        beats.delete();
        drive(1'b0, 16'd0, 1'b1, 16'd4, 1'b1); cycle();
        drive(1'b1, 16'd4, 1'b0, 16'd0, 1'b1); cycle();
        idle(2);
        chk("s3_merged", 128'(merged_cnt), 128'(1));
        chk("s3_dsc_only", 128'(dsc_only_cnt), 128'(1));
        chk("s3_beats", 128'(beats.size()), 128'(1));
        chk_beat("s3_b0", 0, 16'd4, 1'b1, 1'b0);

        // Output held busy; three updates for queue 2 collapse into one.
        beats.delete();
        drive(1'b1, 16'd11, 1'b0, 16'd0, 1'b0); cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 16'd0, 1'b1, 16'd2, 1'b0);
            cycle();
        end
        idle(3);
        chk("s4_coalesced", 128'(coalesced_cnt), 128'(2));
        chk("s4_dsc_only", 128'(dsc_only_cnt), 128'(2));
        chk("s4_beats", 128'(beats.size()), 128'(2));
        chk_beat("s4_b0", 0, 16'd11, 1'b0, 1'b0);
        chk_beat("s4_b1", 1, 16'd2, 1'b0, 1'b1);

        // Packet stream starves the head update for at most BURST_MAX grants; the first
        // packet is granted in the same cycle the update is accepted, before it is pending.
        beats.delete();
        drive(1'b1, 16'd1, 1'b1, 16'd8, 1'b1); cycle();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 16'd1, 1'b0, 16'd0, 1'b1);
            cycle();
        end
        idle(1);
        chk("s5_beats", 128'(beats.size()), 128'(10));
        for (int i = 0; i < 5; i++) chk_beat("s5_pkt", i, 16'd1, 1'b0, 1'b0);
        chk_beat("s5_dsc", 5, 16'd8, 1'b0, 1'b1);
        chk_beat("s5_resume", 6, 16'd1, 1'b0, 1'b0);
        chk("s5_dsc_only", 128'(dsc_only_cnt), 128'(3));

        // Fill the FIFO behind a stalled output, then reset mid-stream.
        drive(1'b1, 16'd11, 1'b0, 16'd0, 1'b0); cycle();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 16'd0, 1'b1, 16'(20 + i), 1'b0);
            cycle();
        end
        drive(1'b0, 16'd0, 1'b1, 16'd30, 1'b0);
        #1;
        chk("s6_full_ready", 128'(head_upd_ready), 128'(0));
        cycle();
        drive(1'b1, 16'd12, 1'b1, 16'd31, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        reset_checks();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        chk("s6_dsc_after_rst", 128'(dsc_only_cnt), 128'(0));
        chk("s6_ready_after_rst", 128'(head_upd_ready), 128'(1));

        // Random traffic: small id ranges to provoke merges, coalescing and a full FIFO.
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 99) < 60, 16'($urandom_range(0, 5)),
                  $urandom_range(0, 99) < 40, 16'($urandom_range(0, 9)),
                  $urandom_range(0, 99) < ((i < 400) ? 70 : 25));
            cycle();
        end
        idle(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
